md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand/HI/LO width in bits; legal values 8..64.
REQ-002 Parameter MUL_LAT, default 5, busy cycles for multiply-class ops; legal values >= 1.
REQ-003 Parameter DIV_LAT, default 10, busy cycles for divide-class ops; legal values >= 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 flush  input  1  abort any in-flight operation.
REQ-007 op  input  4  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MADDU, 7 MSUB, 8 MSUBU, 9 MTHI, 10 MTLO; 11..15 treated as NOP.
REQ-008 rs  input  WIDTH  operand A (multiplicand / dividend / MTHI-MTLO source).
REQ-009 rt  input  WIDTH  operand B (multiplier / divisor).
REQ-010 start  output  1  combinational; high when a compute op (1..8) is accepted this cycle.
REQ-011 busy  output  1  registered; high while an operation is in flight.
REQ-012 hi  output  WIDTH  registered HI.
REQ-013 lo  output  WIDTH  registered LO.

Function
REQ-014 States: IDLE, RUN; busy SHALL equal (state == RUN).
REQ-015 In IDLE, a compute op SHALL be accepted: start = 1, rs/rt/op latched, countdown loaded with MUL_LAT (ops 1,2,5..8) or DIV_LAT (ops 3,4), state -> RUN at the next edge.
REQ-016 start SHALL be 0 in RUN, during flush, and for NOP/MTHI/MTLO.
REQ-017 busy SHALL remain high for exactly the configured latency, in consecutive cycles.
REQ-018 Result SHALL be written to hi/lo on the same edge on which busy falls; the new values SHALL be visible in the first cycle with busy = 0.
REQ-019 hi/lo SHALL hold their values during RUN; results SHALL come only from the latched operands, never from live rs/rt.
REQ-020 Any op presented in RUN (compute, MTHI, MTLO) SHALL be ignored; the issuing pipeline stalls it externally.
REQ-021 MTHI/MTLO in IDLE: hi (resp. lo) <= rs at the next edge, with no busy cycle.
REQ-022 MULT/MULTU: {hi,lo} <= signed/unsigned 2*WIDTH-bit product.
REQ-023 MADD(U)/MSUB(U): {hi,lo} <= {hi,lo} +/- product, modulo 2^(2*WIDTH); the signedness of the product follows the op.
REQ-024 DIV/DIVU: lo <= quotient truncated toward zero; hi <= remainder, which takes the sign of the dividend for DIV.
REQ-025 Divisor zero: the op SHALL run its full DIV_LAT with hi/lo left unchanged.
REQ-026 DIV with dividend = most-negative value and divisor = -1: lo <= most-negative value, hi <= 0.
REQ-027 flush high in RUN: state -> IDLE at the next edge, busy = 0 the following cycle, hi/lo unchanged (no partial commit).
REQ-028 flush high in IDLE: any op on op that cycle, including MTHI/MTLO, SHALL be discarded.
REQ-029 flush on the final busy cycle: flush wins; no commit.
REQ-030 A new compute op MAY be accepted in the first cycle after busy falls (back-to-back issue, no dead cycle).
REQ-031 A new result SHALL be committed exactly once per accepted op; countdown wrap-around SHALL NOT occur.

Reset
REQ-032 reset = 0 at a rising edge SHALL force state IDLE, busy = 0, hi = 0, lo = 0, countdown = 0.
REQ-033 Reset SHALL take priority over flush and op, including mid-operation; no result from an interrupted op SHALL be committed.
REQ-034 start SHALL be 0 while reset = 0.

Verification (WIDTH=32, MUL_LAT=5, DIV_LAT=10)
REQ-035 MULT rs=0xFFFFFFFF, rt=0x00000002 -> start=1 for 1 cycle, busy=1 for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 DIVU 7/2 -> after 10 busy cycles lo=3, hi=1; DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 MTHI 0x12345678, MTLO 0xAAAAAAAA, then DIVU x/0 -> busy 10 cycles, hi/lo unchanged; MTHI issued during busy is ignored.
REQ-038 hi=0, lo=0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0; MSUB 1*1 -> hi=0, lo=0xFFFFFFFF.
REQ-039 MULT accepted, flush on busy cycle 3 -> busy=0 from the next cycle, hi/lo unchanged; repeat with reset=0 on busy cycle 3 -> hi=lo=0, busy=0.
REQ-040 Back-to-back: MULT accepted in the first cycle after a DIV completes -> start=1 that cycle, both results committed in order.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Operands are latched on accept; the result commits on the edge where busy falls.
module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               isCompute, isDiv;
  logic [2*WIDTH-1:0] acc, sProd, uProd, result;
  logic               resultValid;
  logic [WIDTH-1:0]   absA, absB, dvsS, dvsU, magQ, magR, sQuo, sRem, uQuo, uRem;

  assign isCompute = (op >= OP_MULT) && (op <= OP_MSUBU);
  assign isDiv     = (op == OP_DIV) || (op == OP_DIVU);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Signed division runs on magnitudes; a zero divisor is swapped for one
  // only to keep the divider defined, the commit is suppressed anyway.
  always_comb begin
    acc   = {hi_q, lo_q};
    sProd = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    uProd = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    absA  = a_q[WIDTH-1] ? -a_q : a_q;
    absB  = b_q[WIDTH-1] ? -b_q : b_q;
    dvsS  = (absB == '0) ? ONE : absB;
    dvsU  = (b_q == '0) ? ONE : b_q;
    magQ  = absA / dvsS;
    magR  = absA % dvsS;
    sQuo  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -magQ : magQ;
    sRem  = a_q[WIDTH-1] ? -magR : magR;
    uQuo  = a_q / dvsU;
    uRem  = a_q % dvsU;
    result      = acc;
    resultValid = 1'b1;
    case (op_q)
      OP_MULT:  result = sProd;
      OP_MULTU: result = uProd;
      OP_MADD:  result = acc + sProd;
      OP_MADDU: result = acc + uProd;
      OP_MSUB:  result = acc - sProd;
      OP_MSUBU: result = acc - uProd;
      OP_DIV: begin
        result      = {sRem, sQuo};
        resultValid = (b_q != '0);
      end
      OP_DIVU: begin
        result      = {uRem, uQuo};
        resultValid = (b_q != '0);
      end
      default:  resultValid = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (!flush) begin
          if (isCompute) begin
            state_d = RUN;
            cnt_d   = isDiv ? CW'(DIV_LAT) : CW'(MUL_LAT);
            op_d    = op;
            a_d     = rs;
            b_d     = rt;
          end else if (op == OP_MTHI) begin
            hi_d = rs;
          end else if (op == OP_MTLO) begin
            lo_d = rs;
          end
        end
      end
      RUN: begin
        // Flush beats the final-cycle commit so an aborted op never lands.
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (resultValid) begin
            {hi_d, lo_d} = result;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start = reset && !flush && (state_q == IDLE) && isCompute;
    busy  = (state_q == RUN);
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// compared against an arithmetic model of HI/LO.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [3:0]  op;
  logic [31:0] rs, rt;
  logic        start, busy;
  logic [31:0] hi, lo;

  int nCompared   = 0;
  int nMismatched = 0;

  logic [31:0] mHi, mLo;

  md_unit #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .flush(flush), .op(op), .rs(rs), .rt(rt),
    .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic int expLat(input logic [3:0] o);
    case (o)
      4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8: return 5;
      4'd3, 4'd4:                         return 10;
      default:                            return 0;
    endcase
  endfunction

  // HI/LO model built from plain 64-bit arithmetic on the operands.
  task automatic modelApply(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, acc, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {mHi, mLo};
    r = acc;
    case (o)
      4'd1: r = sa * sb;
      4'd2: r = ua * ub;
      4'd3: if (b != 32'd0) begin r[31:0] = 32'(sa / sb); r[63:32] = 32'(sa % sb); end
      4'd4: if (b != 32'd0) r = {a % b, a / b};
      4'd5: r = acc + sa * sb;
      4'd6: r = acc + ua * ub;
      4'd7: r = acc - sa * sb;
      4'd8: r = acc - ua * ub;
      4'd9: r[63:32] = a;
      4'd10: r[31:0] = a;
      default: r = acc;
    endcase
    {mHi, mLo} = r;
  endtask

  // Called on a falling edge; returns on the first falling edge with busy low.
  task automatic doOp(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      output logic st, output int bc, output logic held);
    logic [31:0] h0, l0;
    op = o; rs = a; rt = b;
    #1 st = start;
    h0 = hi; l0 = lo;
    @(negedge clk);
    op = 4'd0; rs = $urandom; rt = $urandom;
    bc = 0; held = 1'b1;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; op = 4'd1; rs = 32'd5; rt = 32'd7;
    repeat (3) @(negedge clk);
    #1;
    nCompared++; if (start !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_start: got %b want 0", start); end
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    nCompared++; if (hi !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
    nCompared++; if (lo !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b1; op = 4'd0;
    mHi = 32'd0; mLo = 32'd0;
  endtask

  task automatic test_mult();
    logic st, held; int bc;
    doOp(4'd1, 32'hFFFFFFFF, 32'h2, st, bc, held);
    nCompared++; if (st !== 1'b1) begin nMismatched++; $display("[TB] FAIL mult_start: got %b want 1", st); end
    nCompared++; if (bc != 5) begin nMismatched++; $display("[TB] FAIL mult_busy: got %0d want 5", bc); end
    nCompared++; if (held !== 1'b1) begin nMismatched++; $display("[TB] FAIL mult_hold: hi/lo changed during busy"); end
    nCompared++; if (hi !== 32'hFFFFFFFF) begin nMismatched++; $display("[TB] FAIL mult_hi: got %h want ffffffff", hi); end
    nCompared++; if (lo !== 32'hFFFFFFFE) begin nMismatched++; $display("[TB] FAIL mult_lo: got %h want fffffffe", lo); end
    doOp(4'd2, 32'hFFFFFFFF, 32'h2, st, bc, held);
    nCompared++; if (hi !== 32'h1) begin nMismatched++; $display("[TB] FAIL multu_hi: got %h want 00000001", hi); end
    nCompared++; if (lo !== 32'hFFFFFFFE) begin nMismatched++; $display("[TB] FAIL multu_lo: got %h want fffffffe", lo); end
    modelApply(4'd2, 32'hFFFFFFFF, 32'h2);
  endtask

  task automatic test_div();
    logic st, held; int bc;
    doOp(4'd4, 32'd7, 32'd2, st, bc, held);
    nCompared++; if (bc != 10) begin nMismatched++; $display("[TB] FAIL divu_busy: got %0d want 10", bc); end
    nCompared++; if (lo !== 32'd3 || hi !== 32'd1) begin nMismatched++; $display("[TB] FAIL divu_res: got hi=%h lo=%h want hi=1 lo=3", hi, lo); end
    doOp(4'd3, 32'hFFFFFFF9, 32'd2, st, bc, held);
    nCompared++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin nMismatched++; $display("[TB] FAIL div_neg: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo); end
    doOp(4'd3, 32'h80000000, 32'hFFFFFFFF, st, bc, held);
    nCompared++; if (lo !== 32'h80000000 || hi !== 32'd0) begin nMismatched++; $display("[TB] FAIL div_ovf: got hi=%h lo=%h want hi=0 lo=80000000", hi, lo); end
    modelApply(4'd3, 32'h80000000, 32'hFFFFFFFF);
  endtask

  task automatic test_divzero_mt();
    logic st, held; int bc;
    doOp(4'd9, 32'h12345678, 32'd0, st, bc, held);
    nCompared++; if (st !== 1'b0 || bc != 0) begin nMismatched++; $display("[TB] FAIL mthi_nobusy: got start=%b busy=%0d want 0/0", st, bc); end
    nCompared++; if (hi !== 32'h12345678) begin nMismatched++; $display("[TB] FAIL mthi_hi: got %h want 12345678", hi); end
    doOp(4'd10, 32'hAAAAAAAA, 32'd0, st, bc, held);
    nCompared++; if (lo !== 32'hAAAAAAAA) begin nMismatched++; $display("[TB] FAIL mtlo_lo: got %h want aaaaaaaa", lo); end
    op = 4'd4; rs = 32'd99; rt = 32'd0;
    @(negedge clk);
    op = 4'd9; rs = 32'hDEADBEEF;
    bc = 0;
    while (busy === 1'b1 && bc < 200) begin
      bc++;
      @(negedge clk);
      if (bc == 1) op = 4'd0;
    end
    op = 4'd0;
    nCompared++; if (bc != 10) begin nMismatched++; $display("[TB] FAIL divzero_busy: got %0d want 10", bc); end
    nCompared++; if (hi !== 32'h12345678 || lo !== 32'hAAAAAAAA) begin nMismatched++; $display("[TB] FAIL divzero_hold: got hi=%h lo=%h want 12345678/aaaaaaaa", hi, lo); end
    mHi = 32'h12345678; mLo = 32'hAAAAAAAA;
  endtask

  task automatic test_madd_msub();
    logic st, held; int bc;
    doOp(4'd9, 32'd0, 32'd0, st, bc, held);
    doOp(4'd10, 32'hFFFFFFFF, 32'd0, st, bc, held);
    doOp(4'd6, 32'd1, 32'd1, st, bc, held);
    nCompared++; if (hi !== 32'd1 || lo !== 32'd0) begin nMismatched++; $display("[TB] FAIL maddu: got hi=%h lo=%h want 1/0", hi, lo); end
    doOp(4'd7, 32'd1, 32'd1, st, bc, held);
    nCompared++; if (bc != 5) begin nMismatched++; $display("[TB] FAIL msub_busy: got %0d want 5", bc); end
    nCompared++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin nMismatched++; $display("[TB] FAIL msub: got hi=%h lo=%h want 0/ffffffff", hi, lo); end
    mHi = 32'd0; mLo = 32'hFFFFFFFF;
  endtask

  task automatic test_flush();
    logic st, held; int bc;
    doOp(4'd9, 32'h11111111, 32'd0, st, bc, held);
    doOp(4'd10, 32'h22222222, 32'd0, st, bc, held);
    op = 4'd1; rs = 32'd3; rt = 32'd4;
    @(negedge clk); op = 4'd0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
    nCompared++; if (hi !== 32'h11111111 || lo !== 32'h22222222) begin nMismatched++; $display("[TB] FAIL flush_hold: got hi=%h lo=%h", hi, lo); end
    op = 4'd1; rs = 32'd3; rt = 32'd4;
    @(negedge clk); op = 4'd0;
    repeat (4) @(negedge clk);
    nCompared++; if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_last_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    nCompared++; if (busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin nMismatched++; $display("[TB] FAIL flush_last: got busy=%b hi=%h lo=%h", busy, hi, lo); end
    flush = 1'b1; op = 4'd9; rs = 32'hFFFF0000;
    @(negedge clk);
    op = 4'd1;
    #1;
    nCompared++; if (start !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_idle_start: got %b want 0", start); end
    @(negedge clk); flush = 1'b0; op = 4'd0;
    nCompared++; if (busy !== 1'b0 || hi !== 32'h11111111) begin nMismatched++; $display("[TB] FAIL flush_idle: got busy=%b hi=%h", busy, hi); end
    mHi = 32'h11111111; mLo = 32'h22222222;
  endtask

  task automatic test_reset_mid();
    op = 4'd1; rs = 32'd3; rt = 32'd4;
    @(negedge clk); op = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    nCompared++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
    repeat (6) @(negedge clk);
    nCompared++; if (hi !== 32'd0 || lo !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_mid_late: got hi=%h lo=%h want 0/0", hi, lo); end
    mHi = 32'd0; mLo = 32'd0;
  endtask

  task automatic test_back_to_back();
    logic st, held; int bc;
    doOp(4'd4, 32'd100, 32'd7, st, bc, held);
    nCompared++; if (hi !== 32'd2 || lo !== 32'd14) begin nMismatched++; $display("[TB] FAIL b2b_div: got hi=%h lo=%h want 2/e", hi, lo); end
    doOp(4'd2, 32'd6, 32'd7, st, bc, held);
    nCompared++; if (st !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_start: got %b want 1", st); end
    nCompared++; if (bc != 5 || hi !== 32'd0 || lo !== 32'd42) begin nMismatched++; $display("[TB] FAIL b2b_mult: got busy=%0d hi=%h lo=%h want 5/0/2a", bc, hi, lo); end
    mHi = 32'd0; mLo = 32'd42;
  endtask

  task automatic test_random();
    logic st, held; int bc;
    logic [3:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: b = $urandom;
        default: b = 32'hFFFFFFFF;
      endcase
      doOp(o, a, b, st, bc, held);
      modelApply(o, a, b);
      nCompared++; if (st !== (expLat(o) != 0)) begin nMismatched++; $display("[TB] FAIL rnd_start op=%0d: got %b", o, st); end
      nCompared++; if (bc != expLat(o)) begin nMismatched++; $display("[TB] FAIL rnd_busy op=%0d: got %0d want %0d", o, bc, expLat(o)); end
      nCompared++; if (held !== 1'b1) begin nMismatched++; $display("[TB] FAIL rnd_hold op=%0d: hi/lo changed during busy", o); end
      nCompared++; if (hi !== mHi || lo !== mLo) begin nMismatched++; $display("[TB] FAIL rnd_result op=%0d a=%h b=%h: got %h_%h want %h_%h", o, a, b, hi, lo, mHi, mLo); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; op = 4'd0; rs = 32'd0; rt = 32'd0;
    mHi = 32'd0; mLo = 32'd0;
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_divzero_mt();
    test_madd_msub();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
